// File: rtl/axi_axis_fifo_reader.sv
// AXI4-Lite read-only slave that buffers an AXI-Stream input in a small FIFO.
// Software pops words from the DATA register and polls fill level and flags from STATUS.
module axi_axis_fifo_reader #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      s_axis_tready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid
);

    localparam int ADDR_LSB  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    localparam logic [1:0] IDX_DATA    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]      count;
    logic                      underflow;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      accept;
    logic [1:0]                reg_idx;
    logic [AXI_DATA_WIDTH-1:0] status_word;
    logic                      unused_addr_bits;

    assign full          = (count == DEPTH_CNT);
    assign empty         = (count == '0);
    assign s_axis_tready = aresetn & (count < DEPTH_CNT);
    assign s_axi_arready = ~s_axi_rvalid | s_axi_rready;
    assign accept        = s_axi_arvalid & s_axi_arready;
    assign reg_idx       = s_axi_araddr[ADDR_LSB+1:ADDR_LSB];
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = accept & (reg_idx == IDX_DATA) & ~empty;

    // Only the word index selects a register; the rest of the address is ignored.
    assign unused_addr_bits = ^s_axi_araddr;

    always_comb begin
        // NOTE: every bit gets a default first so no latch is inferred for the zero fields.
        status_word                   = '0;
        status_word[CNT_WIDTH-1:0]    = count;
        status_word[AXI_DATA_WIDTH-1] = full;
        status_word[AXI_DATA_WIDTH-2] = underflow;
    end

    // NOTE: the storage array has no reset; clearing count and pointers makes stale words unreachable.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= s_axis_tdata;
    end

    // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            underflow    <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (accept) begin
                s_axi_rvalid <= 1'b1;
                case (reg_idx)
                    IDX_DATA: begin
                        s_axi_rresp <= RESP_OKAY;
                        if (empty) begin
                            s_axi_rdata <= '0;
                            underflow   <= 1'b1;
                        end else begin
                            s_axi_rdata <= mem[rd_ptr];
                        end
                    end
                    IDX_STATUS: begin
                        s_axi_rdata <= status_word;
                        s_axi_rresp <= RESP_OKAY;
                        underflow   <= 1'b0;
                    end
                    default: begin
                        s_axi_rdata <= '0;
                        s_axi_rresp <= RESP_SLVERR;
                    end
                endcase
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_axis_fifo_reader.sv
// Cycle-stepped bench for axi_axis_fifo_reader: a queue-based model predicts every
// handshake and response while directed scenarios and a random phase drive the DUT.
module tb_axi_axis_fifo_reader;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;

    axi_axis_fifo_reader #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO contents as a queue plus the visible read-channel state.
    logic [DW-1:0] model_q[$];
    logic          m_underflow = 1'b0;
    logic          m_rvalid    = 1'b0;
    logic [DW-1:0] m_rdata     = '0;
    logic [1:0]    m_rresp     = 2'b00;

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] status_value(input int level, input logic uf);
        logic [DW-1:0] v;
        v         = DW'(level);
        v[DW-1]   = (level == DEPTH);
        v[DW-2]   = uf;
        return v;
    endfunction

    // One clock: drive at posedge+1, predict the edge, then check the result at the next posedge+1.
    task automatic cycle(input logic tv, input logic [DW-1:0] td, input logic av,
                         input logic [1:0] idx, input logic rr);
        int   level;
        logic do_push;
        logic do_accept;
        s_axis_tvalid = tv;
        s_axis_tdata  = td;
        s_axi_arvalid = av;
        s_axi_araddr  = AW'({idx, 2'b00});
        s_axi_rready  = rr;
        #0;
        level     = model_q.size();
        do_push   = tv && (level < DEPTH);
        do_accept = av && (!m_rvalid || rr);
        check("tready", DW'(s_axis_tready), DW'(level < DEPTH));
        check("arready", DW'(s_axi_arready), DW'(!m_rvalid || rr));

        if (do_accept) begin
            m_rvalid = 1'b1;
            case (idx)
                2'd0: begin
                    m_rresp = 2'b00;
                    if (level > 0) m_rdata = model_q.pop_front();
                    else begin
                        m_rdata     = '0;
                        m_underflow = 1'b1;
                    end
                end
                2'd1: begin
                    m_rresp     = 2'b00;
                    m_rdata     = status_value(level, m_underflow);
                    m_underflow = 1'b0;
                end
                default: begin
                    m_rresp = 2'b10;
                    m_rdata = '0;
                end
            endcase
        end else if (rr) begin
            m_rvalid = 1'b0;
        end
        if (do_push) model_q.push_back(td);

        @(posedge aclk);
        #1;
        check("rvalid", DW'(s_axi_rvalid), DW'(m_rvalid));
        if (m_rvalid) begin
            check("rdata", s_axi_rdata, m_rdata);
            check("rresp", DW'(s_axi_rresp), DW'(m_rresp));
        end
    endtask

    task automatic apply_reset(input int cycles);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        #0;
        check("tready_in_reset", DW'(s_axis_tready), '0);
        repeat (cycles) @(posedge aclk);
        #1;
        check("rvalid_after_reset", DW'(s_axi_rvalid), '0);
        check("rdata_after_reset", s_axi_rdata, '0);
        check("rresp_after_reset", DW'(s_axi_rresp), '0);
        model_q.delete();
        m_underflow = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rresp     = 2'b00;
        aresetn     = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] held;
        aresetn       = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        apply_reset(3);

        // Three pushes drained in order, then an empty STATUS.
        cycle(1, 32'h11, 0, 0, 1);
        cycle(1, 32'h22, 0, 0, 1);
        cycle(1, 32'h33, 0, 0, 1);
        cycle(0, 0, 1, 0, 1); check("data_0x11", s_axi_rdata, 32'h11);
        cycle(0, 0, 1, 0, 1); check("data_0x22", s_axi_rdata, 32'h22);
        cycle(0, 0, 1, 0, 1); check("data_0x33", s_axi_rdata, 32'h33);
        cycle(0, 0, 1, 1, 1); check("status_empty", s_axi_rdata, 32'h0);

        // Overfill: the fifth word stalls until a DATA read frees a slot.
        for (int i = 0; i < 5; i++) cycle(1, 32'hA0 + i, 0, 0, 1);
        check("tready_full", DW'(s_axis_tready), '0);
        cycle(1, 32'hA4, 1, 1, 1); check("status_full", s_axi_rdata, 32'h80000004);
        cycle(1, 32'hA4, 1, 0, 1); check("data_head", s_axi_rdata, 32'hA0);
        check("tready_reopened", DW'(s_axis_tready), 32'h1);
        cycle(1, 32'hA4, 0, 0, 1);
        check("level_after_refill", DW'(model_q.size()), 32'd4);

        // Back-to-back DATA reads drain the full FIFO, one beat per cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 1);
            check("b2b_data", s_axi_rdata, 32'hA1 + i);
        end
        cycle(0, 0, 1, 1, 1); check("status_drained", s_axi_rdata, 32'h0);

        // Underflow is sticky until a STATUS read.
        cycle(0, 0, 1, 0, 1); check("underflow_data", s_axi_rdata, 32'h0);
        cycle(0, 0, 1, 1, 1); check("status_underflow", s_axi_rdata, 32'h40000000);
        cycle(0, 0, 1, 1, 1); check("status_uf_cleared", s_axi_rdata, 32'h0);

        // Pop on empty with a simultaneous push keeps the pushed word.
        cycle(1, 32'h5A, 1, 0, 1); check("empty_pop_push", s_axi_rdata, 32'h0);
        cycle(0, 0, 1, 1, 1); check("status_after_pp", s_axi_rdata, 32'h40000001);

        // Backpressure: response held stable for three cycles, then an SLVERR index.
        cycle(1, 32'h77, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        held = s_axi_rdata;
        check("held_data", held, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0);
            check("held_stable", s_axi_rdata, held);
        end
        cycle(0, 0, 1, 2, 1); check("slverr_resp", DW'(s_axi_rresp), 32'h2);
        cycle(0, 0, 1, 1, 1); check("status_unchanged", s_axi_rdata, 32'h00000001);

        // Reset in the middle of a pending response.
        cycle(1, 32'hC1, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        apply_reset(1);
        cycle(0, 0, 1, 1, 1); check("status_post_reset", s_axi_rdata, 32'h0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_axis_fifo_reader.md
Name: axi_axis_fifo_reader

Overview:
- AXI4-Lite read-only slave that drains an AXI-Stream input through an internal FIFO. It replaces the single-word, unbuffered stream reader.
- Software reads stream words from a data register and reads FIFO fill level, full flag and a sticky underflow flag from a status register.
- Sits between a PL stream producer (ADC/decoder output) and the PS general-purpose AXI port, typically behind an AXI interconnect.

Parameters:
- AXI_DATA_WIDTH, 32, width of s_axi_rdata and s_axis_tdata; 32 or 64.
- AXI_ADDR_WIDTH, 16, width of s_axi_araddr.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2. CNT_WIDTH = clog2(FIFO_DEPTH)+1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  AXI_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  AXI_DATA_WIDTH  stream data
- s_axis_tvalid  in  1  stream valid

Behaviour:
- Reset is aresetn, synchronous, active-low; clock is aclk. Everything is on posedge aclk.
- In reset: count=0, rd/wr pointers=0, rvalid=0, rdata=0, rresp=0, underflow=0. s_axis_tready=0 while aresetn low.
- Push: s_axis_tready = aresetn & (count < FIFO_DEPTH). Word stored when tvalid & tready.
  - tready depends only on count, never on a same-cycle pop, so a full FIFO does not accept a push even while popping.
- AR handshake: s_axi_arready = ~rvalid | s_axi_rready. Accept = arvalid & arready.
  - Only one outstanding read; back-to-back reads give one read per cycle when rready is held high.
  - rvalid goes to 1 the cycle after accept. It clears after rvalid & rready unless a new accept occurs in the same cycle.
  - rdata/rresp are registered and stable while rvalid=1 and rready=0.
- Decode uses word index = araddr[ADDR_LSB+1:ADDR_LSB], ADDR_LSB = clog2(AXI_DATA_WIDTH/8).
  - Index 0 (DATA):
    - count>0: rdata=head word, rresp=OKAY, pop at accept (rd pointer and count update at next edge).
    - count=0: rdata=0, rresp=OKAY, underflow set to 1, no pop.
  - Index 1 (STATUS):
    - rdata[CNT_WIDTH-1:0] = count sampled in the accept cycle (before that cycle's push/pop).
    - rdata[AXI_DATA_WIDTH-1] = full (count==FIFO_DEPTH); rdata[AXI_DATA_WIDTH-2] = underflow; all other bits 0.
    - rresp=OKAY. Underflow clears at accept.
  - Index 2, 3: rdata=0, rresp=SLVERR (2'b10). No side effects.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop on empty with a push in the same cycle: returns 0 and sets underflow. The pushed word is kept and count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. count range is 0..FIFO_DEPTH.
- Storage is a register/LUTRAM array with combinational head read, registered into rdata at accept. Total latency from AR accept to rvalid is 1 cycle.
- Reset mid-read discards the pending response (rvalid→0) and the FIFO contents.

Test Plan:
- FIFO_DEPTH=4: push 0x11,0x22,0x33 with rready=1, then 3 DATA reads → rdata 0x11,0x22,0x33, OKAY, in order; STATUS then reads 0x00000000.
- Push 5 words into depth 4 → tready drops after 4th push, 5th stalls. STATUS=0x80000004. One DATA read → tready high again, 5th word accepted.
- DATA read on empty → rdata=0, OKAY. STATUS=0x40000000; second STATUS=0x00000000 (underflow cleared).
- Back-to-back DATA reads with arvalid and rready held high for 4 cycles on a full FIFO → 4 consecutive rvalid beats, one per cycle, correct order, count 0.
- rready held low 3 cycles with rvalid=1 → arready=0, rdata stable; read of index 2 returns rresp=2'b10, rdata=0, FIFO unchanged.
- Push 2 words, assert arvalid, drop aresetn for 1 cycle mid-response → rvalid=0, tready=0 during reset; STATUS after reset reads 0.
